sprite_contact_unit: RTL and testbench

Per-pixel and per-frame helper for the Jack-Frost game datapath. It computes the background ROM address for the current VGA pixel and detects two kinds of contact:

- the player sprite standing on ground blocks, which ices them;
- the player overlapping unfrozen slime monsters, which damages the player.

It also owns the player health counter and the post-hit invulnerability timer. It sits between the VGA controller/position registers and the renderer/game logic.

---
 rtl/sprite_contact_unit.sv | 139 +++++++++++++
 tb/tb_sprite_contact_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_contact_unit.sv
// Computes the background ROM address and detects player contact with ground blocks and slime monsters.
// It also owns the health counter and the invulnerability timer. Latency: 1 cycle to contact outputs, 2 to health. No backpressure.
module sprite_contact_unit #(
  parameter int BG_W          = 551,
  parameter int BG_H          = 401,
  parameter int N_BLK         = 8,
  parameter int N_MON         = 2,
  parameter int INVULN_CYCLES = 300000000,
  parameter int HEALTH_INIT   = 3
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [9:0]         col_addr,
  input  logic [8:0]         row_addr,
  input  logic [9:0]         x_blue,
  input  logic [8:0]         y_blue,
  input  logic [N_BLK*10-1:0] x_ground,
  input  logic [N_BLK*9-1:0]  y_ground,
  input  logic [N_MON*10-1:0] x_slim,
  input  logic [N_MON*9-1:0]  y_slim,
  input  logic [N_MON-1:0]   slim_frozen,
  output logic [18:0]        bg_addr,
  output logic [N_BLK-1:0]   touched,
  output logic [N_BLK-1:0]   iced,
  output logic [N_MON-1:0]   broken,
  output logic               hit,
  output logic [3:0]         health,
  output logic               invuln,
  output logic               dead
);

  localparam int CW = (INVULN_CYCLES > 1) ? $clog2(INVULN_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(INVULN_CYCLES - 1);

  typedef enum logic {
    ARMED = 1'b0,
    GUARD = 1'b1
  } dmg_state_t;

  // All geometry is done in 11 bits so the right/bottom edges never wrap.
  logic [10:0] xb, yb, xb_right, yb_bot, foot;
  assign xb       = {1'b0, x_blue};
  assign yb       = {2'b0, y_blue};
  assign xb_right = xb + 11'd46;
  assign yb_bot   = yb + 11'd40;
  assign foot     = yb + 11'd41;

  logic        in_bg;
  logic [18:0] bg_addr_nxt;
  assign in_bg = (11'(col_addr) <= 11'(BG_W - 1)) && (11'(row_addr) <= 11'(BG_H - 1));
  assign bg_addr_nxt = in_bg ? (19'(row_addr) * 19'(BG_W) + 19'(col_addr)) : 19'd0;

  logic [N_BLK-1:0] touched_nxt;
  logic [N_MON-1:0] broken_nxt;

  genvar i;
  generate
    for (i = 0; i < N_BLK; i++) begin : g_blk
      logic [10:0] xg, yg;
      assign xg = {1'b0, x_ground[10*i +: 10]};
      assign yg = {2'b0, y_ground[9*i +: 9]};
      // Feet must land within the top three rows of the block.
      assign touched_nxt[i] = (xb <= xg + 11'd27) && (xb_right >= xg) &&
                              (foot >= yg) && (foot <= yg + 11'd2);
    end

    for (i = 0; i < N_MON; i++) begin : g_mon
      logic [10:0] xs, ys;
      logic        overlap;
      assign xs = {1'b0, x_slim[10*i +: 10]};
      assign ys = {2'b0, y_slim[9*i +: 9]};
      assign overlap = (xb <= xs + 11'd61) && (xb_right >= xs) &&
                       (yb <= ys + 11'd35) && (yb_bot >= ys);
      assign broken_nxt[i] = overlap && !slim_frozen[i];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rstn) begin
      bg_addr <= '0;
      touched <= '0;
      iced    <= '0;
      broken  <= '0;
    end else begin
      bg_addr <= bg_addr_nxt;
      touched <= touched_nxt;
      iced    <= iced | touched_nxt;
      broken  <= broken_nxt;
    end
  end

  dmg_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    health_nxt;
  logic          hit_nxt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= ARMED;
      cnt    <= '0;
      health <= 4'(HEALTH_INIT);
      hit    <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      health <= health_nxt;
      hit    <= hit_nxt;
    end
  end

  // Overlap seen while guarded is dropped, not queued for later.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    health_nxt = health;
    hit_nxt    = 1'b0;
    case (state)
      ARMED: begin
        if ((|broken) && (health != 4'd0)) begin
          health_nxt = health - 4'd1;
          hit_nxt    = 1'b1;
          cnt_nxt    = CNT_LOAD;
          state_nxt  = GUARD;
        end
      end
      GUARD: begin
        if (cnt == '0) begin
          state_nxt = ARMED;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
    endcase
  end

  assign invuln = (state == GUARD);
  assign dead   = (health == 4'd0);

endmodule

// File: tb/tb_sprite_contact_unit.sv
// Directed bench: stimulus queues expected values per edge, a monitor pops and compares them 1 ns after each rising edge.
module tb_sprite_contact_unit;

  localparam int N_BLK = 8;
  localparam int N_MON = 2;

  localparam int S_BG = 0, S_TOUCHED = 1, S_ICED = 2, S_BROKEN = 3;
  localparam int S_HIT = 4, S_HEALTH = 5, S_INVULN = 6, S_DEAD = 7;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic [9:0]           col_addr;
  logic [8:0]           row_addr;
  logic [9:0]           x_blue;
  logic [8:0]           y_blue;
  logic [N_BLK*10-1:0]  x_ground;
  logic [N_BLK*9-1:0]   y_ground;
  logic [N_MON*10-1:0]  x_slim;
  logic [N_MON*9-1:0]   y_slim;
  logic [N_MON-1:0]     slim_frozen;
  logic [18:0]          bg_addr;
  logic [N_BLK-1:0]     touched;
  logic [N_BLK-1:0]     iced;
  logic [N_MON-1:0]     broken;
  logic                 hit;
  logic [3:0]           health;
  logic                 invuln;
  logic                 dead;

  always #5 clk = ~clk;

  sprite_contact_unit #(
    .BG_W(551), .BG_H(401), .N_BLK(N_BLK), .N_MON(N_MON),
    .INVULN_CYCLES(10), .HEALTH_INIT(3)
  ) dut (
    .clk(clk), .rstn(rstn), .col_addr(col_addr), .row_addr(row_addr),
    .x_blue(x_blue), .y_blue(y_blue), .x_ground(x_ground), .y_ground(y_ground),
    .x_slim(x_slim), .y_slim(y_slim), .slim_frozen(slim_frozen),
    .bg_addr(bg_addr), .touched(touched), .iced(iced), .broken(broken),
    .hit(hit), .health(health), .invuln(invuln), .dead(dead)
  );

  typedef struct {
    int at;
    int sel;
    int val;
  } exp_t;

  exp_t sb[$];
  int   edge_n = 0;
  int   checks = 0;
  int   errors = 0;

  function automatic int actual(input int sel);
    case (sel)
      S_BG:      return int'(bg_addr);
      S_TOUCHED: return int'(touched);
      S_ICED:    return int'(iced);
      S_BROKEN:  return int'(broken);
      S_HIT:     return int'(hit);
      S_HEALTH:  return int'(health);
      S_INVULN:  return int'(invuln);
      default:   return int'(dead);
    endcase
  endfunction

  function automatic string sig_name(input int sel);
    case (sel)
      S_BG:      return "bg_addr";
      S_TOUCHED: return "touched";
      S_ICED:    return "iced";
      S_BROKEN:  return "broken";
      S_HIT:     return "hit";
      S_HEALTH:  return "health";
      S_INVULN:  return "invuln";
      default:   return "dead";
    endcase
  endfunction

  task automatic expect_at(input int d, input int sel, input int val);
    exp_t e;
    e.at  = edge_n + d;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic put_player(input int x, input int y);
    x_blue = 10'(x);
    y_blue = 9'(y);
  endtask

  // Monitor: compare every entry due on this edge.
  always @(posedge clk) begin
    edge_n++;
    #1;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == edge_n) begin
        checks++;
        if (actual(sb[i].sel) != sb[i].val) begin
          errors++;
          $display("FAIL %s at edge %0d: got %0d, expected %0d",
                   sig_name(sb[i].sel), edge_n, actual(sb[i].sel), sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rstn        = 1'b0;
    col_addr    = '0;
    row_addr    = '0;
    put_player(600, 300);
    for (int i = 0; i < N_BLK; i++) begin
      x_ground[10*i +: 10] = 10'd1000;
      y_ground[9*i +: 9]   = 9'd500;
    end
    for (int j = 0; j < N_MON; j++) begin
      x_slim[10*j +: 10] = 10'd1000;
      y_slim[9*j +: 9]   = 9'd500;
    end
    slim_frozen = '0;

    // Reset state
    tick(1);
    rstn = 1'b0;
    expect_at(1, S_BG, 0);     expect_at(1, S_TOUCHED, 0); expect_at(1, S_ICED, 0);
    expect_at(1, S_BROKEN, 0); expect_at(1, S_HIT, 0);     expect_at(1, S_HEALTH, 3);
    expect_at(1, S_INVULN, 0); expect_at(1, S_DEAD, 0);
    tick(1);
    rstn = 1'b1;

    // Background address, one per cycle
    col_addr = 10'd0;   row_addr = 9'd0;   expect_at(1, S_BG, 0);      tick(1);
    col_addr = 10'd550; row_addr = 9'd400; expect_at(1, S_BG, 220950); tick(1);
    col_addr = 10'd551; row_addr = 9'd10;  expect_at(1, S_BG, 0);      tick(1);
    col_addr = 10'd5;   row_addr = 9'd401; expect_at(1, S_BG, 0);      tick(1);
    col_addr = 10'd10;  row_addr = 9'd2;   expect_at(1, S_BG, 1112);   tick(1);

    // Ground contact and sticky iced
    x_ground[9:0] = 10'd28;
    y_ground[8:0] = 9'd374;
    put_player(0, 333);  expect_at(1, S_TOUCHED, 1); expect_at(1, S_ICED, 1); tick(1);
    put_player(0, 300);  expect_at(1, S_TOUCHED, 0); expect_at(1, S_ICED, 1); tick(1);
    put_player(75, 333); expect_at(1, S_TOUCHED, 0); tick(1);
    put_player(0, 335);  expect_at(1, S_TOUCHED, 1); tick(1);
    put_player(0, 336);  expect_at(1, S_TOUCHED, 0); tick(1);
    x_ground[30 +: 10] = 10'd100;
    y_ground[27 +: 9]  = 9'd200;
    put_player(80, 159); expect_at(1, S_TOUCHED, 8); expect_at(1, S_ICED, 9); tick(1);
    rstn = 1'b0;
    put_player(600, 300);
    expect_at(1, S_ICED, 0); expect_at(1, S_TOUCHED, 0);
    tick(1);
    rstn = 1'b1;

    // Single monster hit, guard window, second hit
    x_slim[9:0] = 10'd48;
    y_slim[8:0] = 9'd0;
    put_player(2, 0);
    expect_at(1, S_BROKEN, 1);
    expect_at(1, S_HIT, 0);
    expect_at(2, S_HIT, 1); expect_at(2, S_HEALTH, 2); expect_at(2, S_INVULN, 1);
    for (int d = 3; d <= 12; d++) expect_at(d, S_HIT, 0);
    expect_at(11, S_INVULN, 1);
    expect_at(12, S_INVULN, 0); expect_at(12, S_HEALTH, 2);
    expect_at(13, S_HIT, 1); expect_at(13, S_HEALTH, 1); expect_at(13, S_INVULN, 1);
    tick(13);

    // Reset while guarded
    rstn = 1'b0;
    put_player(600, 300);
    expect_at(1, S_INVULN, 0); expect_at(1, S_HEALTH, 3);
    expect_at(1, S_HIT, 0);    expect_at(1, S_BROKEN, 0);
    tick(1);
    rstn = 1'b1;

    // Frozen monster and near-miss boundaries
    slim_frozen = 2'b01;
    put_player(2, 0);
    expect_at(1, S_BROKEN, 0); expect_at(2, S_HIT, 0); expect_at(2, S_HEALTH, 3);
    tick(2);
    slim_frozen = 2'b00;
    put_player(110, 0);
    expect_at(1, S_BROKEN, 0); expect_at(2, S_HIT, 0); expect_at(2, S_HEALTH, 3);
    tick(1);
    put_player(2, 36);
    expect_at(1, S_BROKEN, 0); expect_at(2, S_HIT, 0); expect_at(2, S_HEALTH, 3);
    tick(1);
    put_player(600, 300);
    tick(2);

    // Dual overlap held until health saturates at zero
    x_slim[19:10] = 10'd48;
    y_slim[17:9]  = 9'd0;
    put_player(2, 0);
    expect_at(1, S_BROKEN, 3);
    expect_at(1, S_HIT, 0);
    for (int d = 2; d <= 40; d++) expect_at(d, S_HIT, (d == 2 || d == 13 || d == 24) ? 1 : 0);
    expect_at(2, S_HEALTH, 2);  expect_at(2, S_INVULN, 1);
    expect_at(12, S_HEALTH, 2); expect_at(12, S_INVULN, 0);
    expect_at(13, S_HEALTH, 1);
    expect_at(23, S_HEALTH, 1); expect_at(23, S_DEAD, 0);
    expect_at(24, S_HEALTH, 0); expect_at(24, S_DEAD, 1);
    expect_at(40, S_HEALTH, 0); expect_at(40, S_DEAD, 1);
    tick(41);

    tick(3);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
